// File: rtl/nemesis_vol_sched.sv
// rtl/nemesis_vol_sched.sv - shared volume LUT scheduler for PSG channels
// Round-robin issues queued volume codes to one LUT and captures the results per channel.
module nemesis_vol_sched #(
  parameter int NCH = 6,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       comp,
  input  logic [5*NCH-1:0] din,
  input  logic [NCH-1:0]   upd,
  output logic [1:0]       lut_comp,
  output logic [4:0]       lut_din,
  input  logic [7:0]       lut_dout,
  output logic [8*NCH-1:0] vol,
  output logic             busy,
  output logic             frame_done
);
  localparam int PW = $clog2(NCH);
  localparam logic [PW-1:0] LAST = PW'(NCH - 1);

  logic [4:0]     code   [NCH];
  logic [7:0]     vol_q  [NCH];
  logic [NCH-1:0] pending;
  logic [1:0]     comp_q;
  logic [4:0]     din_q;
  logic [PW-1:0]  rr_ptr;
  logic [LAT:0]   tag_v;
  logic [PW-1:0]  tag_ch [LAT+1];
  logic           done_q;

  logic           found;
  logic [PW-1:0]  sel;
  logic [PW:0]    scan;
  logic [NCH-1:0] clr;
  logic [NCH-1:0] set;
  logic [NCH-1:0] pending_nxt;
  logic [LAT:0]   tag_v_nxt;
  logic           cfg_chg;

  // First pending channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    scan  = '0;
    clr   = '0;
    for (int k = 0; k < NCH; k++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(NCH)) scan = scan - (PW+1)'(NCH);
      if (!found && pending[scan[PW-1:0]]) begin
        found = 1'b1;
        sel   = scan[PW-1:0];
      end
    end
    if (found) clr[sel] = 1'b1;
  end

  assign cfg_chg     = (comp != comp_q);
  assign set         = upd | {NCH{cfg_chg}};
  // Set wins over the issue clear so a same-edge repost is not lost.
  assign pending_nxt = (pending & ~clr) | set;
  assign tag_v_nxt   = {tag_v[LAT-1:0], found};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        code[i]  <= '0;
        vol_q[i] <= '0;
      end
      for (int k = 0; k <= LAT; k++) tag_ch[k] <= '0;
      pending <= '0;
      comp_q  <= '0;
      din_q   <= '0;
      rr_ptr  <= '0;
      tag_v   <= '0;
      done_q  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      comp_q  <= comp;
      for (int i = 0; i < NCH; i++) begin
        if (upd[i]) code[i] <= din[5*i +: 5];
      end
      if (found) begin
        din_q  <= code[sel];
        rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
      end
      tag_v     <= tag_v_nxt;
      tag_ch[0] <= sel;
      for (int k = 1; k <= LAT; k++) tag_ch[k] <= tag_ch[k-1];
      if (tag_v[LAT]) vol_q[tag_ch[LAT]] <= lut_dout;
      done_q <= tag_v[LAT] && (pending_nxt == '0) && (tag_v_nxt == '0);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_vol
    assign vol[8*i +: 8] = vol_q[i];
  end

  assign lut_comp   = comp_q;
  assign lut_din    = din_q;
  assign busy       = (|pending) | (|tag_v);
  assign frame_done = done_q;
endmodule

// File: tb/tb_nemesis_vol_sched.sv
// tb/tb_nemesis_vol_sched.sv - bench for nemesis_vol_sched at LUT latencies 1 and 3
module tb_nemesis_vol_sched;
  localparam int NCH = 6;
  localparam int LA  = 1;
  localparam int LB  = 3;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       comp  = 2'd0;
  logic [5*NCH-1:0] din   = '0;
  logic [NCH-1:0]   upd   = '0;
  logic [1:0]       lc_a, lc_b;
  logic [4:0]       ld_a, ld_b;
  logic [7:0]       lo_a, lo_b;
  logic [8*NCH-1:0] vol_a, vol_b;
  logic             busy_a, busy_b, fd_a, fd_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nemesis_vol_sched #(.NCH(NCH), .LAT(LA)) u_a (
    .clk(clk), .rst_n(rst_n), .comp(comp), .din(din), .upd(upd),
    .lut_comp(lc_a), .lut_din(ld_a), .lut_dout(lo_a), .vol(vol_a),
    .busy(busy_a), .frame_done(fd_a));

  nemesis_vol_sched #(.NCH(NCH), .LAT(LB)) u_b (
    .clk(clk), .rst_n(rst_n), .comp(comp), .din(din), .upd(upd),
    .lut_comp(lc_b), .lut_din(ld_b), .lut_dout(lo_b), .vol(vol_b),
    .busy(busy_b), .frame_done(fd_b));

  function automatic logic [7:0] lut_f(input logic [1:0] c, input logic [4:0] cd);
    logic [7:0] b;
    case (cd)
      5'd31:   b = 8'd255;
      5'd20:   b = 8'd129;
      5'd21:   b = 8'd144;
      default: b = 8'(int'(cd) * 7 + 1);
    endcase
    return b ^ {c, 6'd0};
  endfunction

  // External LUT stand-ins: LAT register stages after the address.
  logic [7:0] pa [LA] = '{default: 8'd0};
  logic [7:0] pb [LB] = '{default: 8'd0};
  always @(posedge clk) begin
    pa[0] <= lut_f(lc_a, ld_a);
    for (int k = 1; k < LA; k++) pa[k] <= pa[k-1];
    pb[0] <= lut_f(lc_b, ld_b);
    for (int k = 1; k < LB; k++) pb[k] <= pb[k-1];
  end
  assign lo_a = pa[LA-1];
  assign lo_b = pb[LB-1];

  typedef struct {
    int         cyc;
    int         ch;
    logic [4:0] code;
    logic [1:0] cmp;
  } ev_t;

  ev_t        qa[$];
  ev_t        qb[$];
  int         cyc = 0;
  int         m_rr = 0;
  logic [4:0] m_code [NCH] = '{default: 5'd0};
  logic [7:0] m_vol_a [NCH] = '{default: 8'd0};
  logic [7:0] m_vol_b [NCH] = '{default: 8'd0};
  logic [NCH-1:0] m_pend = '0;
  logic [1:0] m_comp = 2'd0;
  logic [4:0] m_din = 5'd0;
  logic       m_fd_a = 1'b0;
  logic       m_fd_b = 1'b0;

  // Queue-of-lookups model: a lookup issued at cycle c lands at cycle c+1+LAT.
  always @(posedge clk or negedge rst_n) begin : model
    ev_t e;
    int  sel;
    bit  wa, wb;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_code[i] = '0; m_vol_a[i] = '0; m_vol_b[i] = '0;
      end
      qa.delete(); qb.delete();
      m_pend = '0; m_rr = 0; m_comp = '0; m_din = '0; m_fd_a = 0; m_fd_b = 0;
    end else begin
      cyc++;
      wa = 0; wb = 0;
      while (qa.size() > 0 && qa[0].cyc + 1 + LA == cyc) begin
        e = qa.pop_front(); m_vol_a[e.ch] = lut_f(e.cmp, e.code); wa = 1;
      end
      while (qb.size() > 0 && qb[0].cyc + 1 + LB == cyc) begin
        e = qb.pop_front(); m_vol_b[e.ch] = lut_f(e.cmp, e.code); wb = 1;
      end
      sel = -1;
      for (int k = 0; k < NCH; k++)
        if (sel < 0 && m_pend[(m_rr + k) % NCH]) sel = (m_rr + k) % NCH;
      if (sel >= 0) begin
        m_din = m_code[sel]; m_pend[sel] = 1'b0; m_rr = (sel + 1) % NCH;
      end
      for (int i = 0; i < NCH; i++)
        if (upd[i]) begin m_code[i] = din[5*i +: 5]; m_pend[i] = 1'b1; end
      if (comp != m_comp) begin m_comp = comp; m_pend = '1; end
      if (sel >= 0) begin
        e = '{cyc, sel, m_din, m_comp};
        qa.push_back(e); qb.push_back(e);
      end
      m_fd_a = wa && (m_pend == '0) && (qa.size() == 0);
      m_fd_b = wb && (m_pend == '0) && (qb.size() == 0);
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, idx, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("lut_din_a", 0, 32'(ld_a), 32'(m_din));
    chk("lut_din_b", 0, 32'(ld_b), 32'(m_din));
    chk("lut_comp_a", 0, 32'(lc_a), 32'(m_comp));
    chk("lut_comp_b", 0, 32'(lc_b), 32'(m_comp));
    chk("busy_a", 0, 32'(busy_a), 32'((m_pend != '0) || (qa.size() > 0)));
    chk("busy_b", 0, 32'(busy_b), 32'((m_pend != '0) || (qb.size() > 0)));
    chk("frame_done_a", 0, 32'(fd_a), 32'(m_fd_a));
    chk("frame_done_b", 0, 32'(fd_b), 32'(m_fd_b));
    for (int i = 0; i < NCH; i++) begin
      chk("vol_a", i, 32'(vol_a[8*i +: 8]), 32'(m_vol_a[i]));
      chk("vol_b", i, 32'(vol_b[8*i +: 8]), 32'(m_vol_b[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < 40) begin
      tick();
      n++;
    end
    chk("idle_timeout", 0, 32'(n < 40), 32'd1);
    tick();
    tick();
  endtask

  int bexp [NCH] = '{8, 15, 22, 29, 36, 43};
  int cexp [NCH] = '{199, 16, 127, 157, 227, 48};

  initial begin
    int nfd;
    #1 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      upd  = 6'(k * 21 + 5);
      din  = 30'($urandom);
      comp = 2'(k + 1);
    end
    tick();
    chk("rst_vol_a", 0, 32'(vol_a == '0), 32'd1);
    chk("rst_vol_b", 0, 32'(vol_b == '0), 32'd1);
    chk("rst_lut_din", 0, 32'(ld_a), 32'd0);
    chk("rst_lut_comp", 0, 32'(lc_a), 32'd0);
    chk("rst_busy", 0, 32'(busy_a | busy_b), 32'd0);
    chk("rst_frame_done", 0, 32'(fd_a | fd_b), 32'd0);
    upd = '0; din = '0; comp = 2'd0; rst_n = 1'b1;
    tick(); tick();

    // Burst: all channels, codes 1..6, from rr_ptr 0.
    for (int i = 0; i < NCH; i++) din[5*i +: 5] = 5'(i + 1);
    upd = '1;
    tick();
    upd = '0;
    for (int k = 1; k <= NCH; k++) begin
      tick();
      chk("burst_lut_din", k, 32'(ld_a), 32'(k));
      chk("burst_fd_early", k, 32'(fd_a), 32'd0);
    end
    tick();
    chk("burst_fd_early", 7, 32'(fd_a), 32'd0);
    tick();
    for (int i = 0; i < NCH; i++) chk("burst_vol", i, 32'(vol_a[8*i +: 8]), 32'(bexp[i]));
    chk("burst_fd", 0, 32'(fd_a), 32'd1);
    chk("burst_busy", 0, 32'(busy_a), 32'd0);
    wait_idle();

    // Single update on channel 2, idle latency.
    din[14:10] = 5'd31; upd = 6'b000100;
    tick();
    upd = '0;
    tick();
    chk("single_lut_din", 0, 32'(ld_a), 32'd31);
    chk("single_busy", 0, 32'(busy_a), 32'd1);
    tick();
    chk("single_vol_old", 2, 32'(vol_a[23:16]), 32'd22);
    chk("single_fd_early", 0, 32'(fd_a), 32'd0);
    tick();
    chk("single_vol", 2, 32'(vol_a[23:16]), 32'd255);
    chk("single_other", 1, 32'(vol_a[15:8]), 32'd15);
    chk("single_fd", 0, 32'(fd_a), 32'd1);
    chk("single_busy_end", 0, 32'(busy_a), 32'd0);
    tick();
    chk("single_fd_pulse", 0, 32'(fd_a), 32'd0);
    wait_idle();

    // Fairness: ch5 first, then ch0 and ch4 reposted every clock.
    din[29:25] = 5'd25; upd = 6'b100000;
    tick();
    din[4:0] = 5'd10; din[24:20] = 5'd14; upd = 6'b010001;
    tick();
    chk("fair_lut_din", 0, 32'(ld_a), 32'd25);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("fair_lut_din", k + 1, 32'(ld_a), (k % 2 == 0) ? 32'd10 : 32'd14);
    end
    upd = '0;
    wait_idle();

    // Repost of channel 1 on its own issue edge.
    din[9:5] = 5'd20; upd = 6'b000010;
    tick();
    din[9:5] = 5'd21;
    tick();
    chk("conf_lut_din", 0, 32'(ld_a), 32'd20);
    upd = '0;
    tick();
    chk("conf_lut_din", 1, 32'(ld_a), 32'd21);
    tick();
    chk("conf_vol", 0, 32'(vol_a[15:8]), 32'd129);
    chk("conf_fd_early", 0, 32'(fd_a), 32'd0);
    tick();
    chk("conf_vol", 1, 32'(vol_a[15:8]), 32'd144);
    chk("conf_fd", 0, 32'(fd_a), 32'd1);
    wait_idle();

    // Compression 0 -> 2 re-evaluates every channel.
    comp = 2'd2;
    tick();
    chk("comp_lut_comp", 0, 32'(lc_b), 32'd2);
    chk("comp_busy", 0, 32'(busy_b), 32'd1);
    nfd = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      nfd += int'(fd_b);
    end
    chk("comp_fd_count", 0, 32'(nfd), 32'd1);
    for (int i = 0; i < NCH; i++) chk("comp_vol_b", i, 32'(vol_b[8*i +: 8]), 32'(cexp[i]));
    wait_idle();

    // Reset in the middle of a burst.
    upd = '1;
    tick();
    upd = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_vol_a", 0, 32'(vol_a == '0), 32'd1);
    chk("midrst_vol_b", 0, 32'(vol_b == '0), 32'd1);
    chk("midrst_busy", 0, 32'(busy_a | busy_b), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
